tamagotchi_input_hub: RTL and testbench

Parametrised N-channel input conditioner and event queue between the raw pet inputs (push-buttons, ultrasonic presence, tilt flags) and the tamagotchi state machine. Each channel is synchronised, polarity-normalised and debounced. Each channel then produces short-press and long-press events. Events are arbitrated by fixed priority into a FIFO read by a valid/ready handshake, replacing the per-button one-off pulse wiring with one uniform stream.

---
 rtl/tamagotchi_input_hub.sv | 200 ++++++++++++++++++++
 tb/tb_tamagotchi_input_hub.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_input_hub.sv
// Input conditioner for the pet's buttons and sensors: synchronise, debounce,
// classify short/long presses and funnel them through one prioritised event FIFO.

module tih_channel #(
    parameter int   DEBOUNCE_CYCLES   = 1000000,
    parameter int   LONG_PRESS_CYCLES = 250000000,
    parameter logic ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic raise,
    output logic raise_long
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int HD_W = $clog2(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {IDLE, HELD, LONG_SENT} hold_st_t;

    logic [1:0]      sync;
    logic            s;
    logic [DB_W-1:0] db;
    logic [HD_W-1:0] hcnt;
    hold_st_t        st;

    // Synchroniser idles at the inactive raw level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= {2{ACTIVE_LOW}};
        else     sync <= {sync[0], raw};
    end

    assign s = sync[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db    <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            db <= '0;
        end else if (db == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= s;
            db    <= '0;
        end else begin
            db <= db + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            hcnt <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (level) begin
                        st   <= HELD;
                        hcnt <= '0;
                    end
                end
                HELD: begin
                    if (!level)                                   st <= IDLE;
                    else if (hcnt == HD_W'(LONG_PRESS_CYCLES - 1)) st <= LONG_SENT;
                    else                                          hcnt <= hcnt + 1'b1;
                end
                LONG_SENT: begin
                    if (!level) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    // A release in HELD beats the terminal count, so a tie reports short.
    always_comb begin
        raise      = (st == HELD) && (!level || hcnt == HD_W'(LONG_PRESS_CYCLES - 1));
        raise_long = (st == HELD) && level;
    end
endmodule

module tamagotchi_input_hub #(
    parameter int              N_CH              = 6,
    parameter int              DEBOUNCE_CYCLES   = 1000000,
    parameter int              LONG_PRESS_CYCLES = 250000000,
    parameter logic [N_CH-1:0] ACTIVE_LOW        = {N_CH{1'b1}},
    parameter int              EVT_DEPTH         = 4,
    localparam int             CH_W              = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_long,
    input  logic            evt_ready,
    output logic            ovf,
    input  logic            ovf_clr
);
    localparam int PTR_W = $clog2(EVT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            lng;
    } evt_t;

    logic [N_CH-1:0] raise, raise_long;
    logic [N_CH-1:0] pend_vld, pend_long;
    logic [N_CH-1:0] gnt_oh;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_vld, gnt_long;
    logic            push, pop, lost;

    evt_t             mem [EVT_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] cnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tih_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .ACTIVE_LOW       (ACTIVE_LOW[i])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw       (raw_in[i]),
            .level     (level_out[i]),
            .raise     (raise[i]),
            .raise_long(raise_long[i])
        );
    end

    // Fixed priority: lowest channel index wins the single FIFO write slot.
    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        gnt_vld  = 1'b0;
        gnt_long = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (pend_vld[i] && !gnt_vld) begin
                gnt_oh[i] = 1'b1;
                gnt_idx   = CH_W'(i);
                gnt_long  = pend_long[i];
                gnt_vld   = 1'b1;
            end
        end
    end

    assign evt_valid = (cnt != '0);
    assign pop       = evt_valid && evt_ready;
    assign push      = gnt_vld && ((cnt != CNT_W'(EVT_DEPTH)) || pop);
    assign lost      = |(raise & pend_vld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld  <= '0;
            pend_long <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (raise[i] && !pend_vld[i]) begin
                    pend_vld[i]  <= 1'b1;
                    pend_long[i] <= raise_long[i];
                end else if (push && gnt_oh[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ovf <= 1'b0;
        else if (lost)     ovf <= 1'b1;
        else if (ovf_clr)  ovf <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < EVT_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{ch: gnt_idx, lng: gnt_long};
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Show-ahead head: the entry at rptr is presented whenever the FIFO is non-empty.
    assign evt_ch   = mem[rptr].ch;
    assign evt_long = mem[rptr].lng;
endmodule

// File: tb/tb_tamagotchi_input_hub.sv
// Scoreboard bench for tamagotchi_input_hub: small timing constants, event order
// checked against a queue of expected {ch,long} entries.

module tb_tamagotchi_input_hub;
    localparam int N_CH  = 4;
    localparam int DB    = 4;
    localparam int LP    = 20;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] raw_in = '0;
    logic [N_CH-1:0] level_out;
    logic            evt_valid;
    logic [1:0]      evt_ch;
    logic            evt_long;
    logic            evt_ready = 1'b1;
    logic            ovf;
    logic            ovf_clr = 1'b0;

    always #5 clk = ~clk;

    tamagotchi_input_hub #(
        .N_CH             (N_CH),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .ACTIVE_LOW       (4'b0000),
        .EVT_DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .level_out(level_out),
        .evt_valid(evt_valid),
        .evt_ch   (evt_ch),
        .evt_long (evt_long),
        .evt_ready(evt_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    typedef struct {
        int ch;
        int lng;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Every accepted head must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_evt", 32'(evt_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ch", 32'(evt_ch), e.ch);
                chk("sb_long", 32'(evt_long), e.lng);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lvl(input int ch, input logic v, output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (level_out[ch] === v) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_evt(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (evt_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
        $fatal(1);
    end

    initial begin
        int   n;
        logic seen;

        repeat (3) tick();
        chk("rst_level", 32'(level_out), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ch", 32'(evt_ch), 0);
        chk("rst_long", 32'(evt_long), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: bounce then short press on ch1
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            raw_in[1] = ((i / 2) % 2) == 1;
            tick();
            seen |= level_out[1];
        end
        chk("t1_bounce_no_rise", 32'(seen), 0);
        raw_in[1] = 1'b1;
        wait_lvl(1, 1'b1, n);
        chk("t1_rise_lat", n, 6);
        tick();
        tick();
        chk("t1_level_held", 32'(level_out[1]), 1);
        raw_in[1] = 1'b0;
        exp_q.push_back('{1, 0});
        wait_lvl(1, 1'b0, n);
        chk("t1_fall_lat", n, 6);
        tick();
        chk("t1_evt_early", 32'(evt_valid), 0);
        tick();
        chk("t1_evt_lat", 32'(evt_valid), 1);
        repeat (3) tick();
        chk("t1_sb_empty", exp_q.size(), 0);

        // 2: long press on ch2, nothing on release
        raw_in[2] = 1'b1;
        exp_q.push_back('{2, 1});
        wait_lvl(2, 1'b1, n);
        chk("t2_rise_lat", n, 6);
        wait_evt(n);
        chk("t2_long_lat", n, 22);
        repeat (12) tick();
        raw_in[2] = 1'b0;
        wait_lvl(2, 1'b0, n);
        chk("t2_fall_lat", n, 6);
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen |= evt_valid;
        end
        chk("t2_no_release_evt", 32'(seen), 0);
        chk("t2_sb_empty", exp_q.size(), 0);

        // 3: simultaneous release of ch0 and ch3
        raw_in[0] = 1'b1;
        raw_in[3] = 1'b1;
        wait_lvl(0, 1'b1, n);
        tick();
        tick();
        raw_in[0] = 1'b0;
        raw_in[3] = 1'b0;
        exp_q.push_back('{0, 0});
        exp_q.push_back('{3, 0});
        wait_lvl(0, 1'b0, n);
        chk("t3_fall3", 32'(level_out[3]), 0);
        tick();
        tick();
        chk("t3_first_valid", 32'(evt_valid), 1);
        chk("t3_first_ch", 32'(evt_ch), 0);
        tick();
        chk("t3_second_valid", 32'(evt_valid), 1);
        chk("t3_second_ch", 32'(evt_ch), 3);
        tick();
        chk("t3_drained", 32'(evt_valid), 0);

        // 4: backpressure, ch2 left pending, then overflow behaviour
        evt_ready = 1'b0;
        raw_in[2:0] = 3'b111;
        wait_lvl(0, 1'b1, n);
        tick();
        tick();
        raw_in[2:0] = 3'b000;
        exp_q.push_back('{0, 0});
        exp_q.push_back('{1, 0});
        exp_q.push_back('{2, 0});
        wait_lvl(0, 1'b0, n);
        repeat (4) tick();
        chk("t4_head_valid", 32'(evt_valid), 1);
        chk("t4_head_ch", 32'(evt_ch), 0);
        chk("t4_fifo_full", 32'(dut.cnt), 2);
        chk("t4_ovf_before", 32'(ovf), 0);

        raw_in[2] = 1'b1;
        wait_lvl(2, 1'b1, n);
        tick();
        tick();
        raw_in[2] = 1'b0;
        wait_lvl(2, 1'b0, n);
        tick();
        tick();
        chk("t4_ovf_set", 32'(ovf), 1);

        raw_in[2] = 1'b1;
        wait_lvl(2, 1'b1, n);
        tick();
        tick();
        raw_in[2] = 1'b0;
        wait_lvl(2, 1'b0, n);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_ovf_loss_wins", 32'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", 32'(ovf), 0);

        // 5: full FIFO with a same-cycle pop and pending push
        evt_ready = 1'b1;
        tick();
        chk("t5_cnt_full_pushpop", 32'(dut.cnt), 2);
        chk("t5_head_ch1", 32'(evt_ch), 1);
        chk("t5_no_loss", 32'(ovf), 0);
        tick();
        chk("t4_drain_ch2", 32'(evt_ch), 2);
        chk("t4_drain_valid", 32'(evt_valid), 1);
        tick();
        chk("t4_drained", 32'(evt_valid), 0);
        chk("t4_sb_empty", exp_q.size(), 0);

        // 6: reset in the middle of a ch1 hold
        raw_in[1] = 1'b1;
        wait_lvl(1, 1'b1, n);
        repeat (10) tick();
        chk("t6_level_before", 32'(level_out[1]), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_level", 32'(level_out), 0);
        chk("t6_rst_valid", 32'(evt_valid), 0);
        chk("t6_rst_ch", 32'(evt_ch), 0);
        chk("t6_rst_long", 32'(evt_long), 0);
        chk("t6_rst_ovf", 32'(ovf), 0);
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        exp_q.push_back('{1, 1});
        wait_lvl(1, 1'b1, n);
        chk("t6_rise_lat", n, 6);
        wait_evt(n);
        chk("t6_long_lat", n, 22);
        raw_in[1] = 1'b0;
        wait_lvl(1, 1'b0, n);
        repeat (4) tick();
        chk("t6_no_release_evt", 32'(evt_valid), 0);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
